mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch port and a data
// port. A three-state FSM (IDLE -> BUSY -> RESP) grants one requester at a
// time. Data normally wins. After DM_STREAK back-to-back data grants made
// while a fetch was waiting, the fetch wins. A BUSY access with no mem_ack
// for TIMEOUT cycles is force-completed with zero read data, and the sticky
// err flag is set.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   if_req     : fetch request, held until if_ready
//   if_addr    : fetch byte address
//   if_rdata   : fetched word, valid while if_ready=1
//   if_ready   : one-cycle fetch completion pulse
//   dm_req     : data request, held until dm_ready
//   dm_we      : 1 = store, 0 = load
//   dm_addr    : data byte address
//   dm_wdata   : store data
//   dm_rdata   : load data (0 for stores), valid while dm_ready=1
//   dm_ready   : one-cycle data completion pulse
//   mem_req    : memory request, high for the whole BUSY phase
//   mem_we     : memory write enable
//   mem_addr   : memory word address (byte address with [1:0] cleared)
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, valid with mem_ack
//   mem_ack    : one-cycle memory completion
//   stall      : pipeline hold, (if_req & ~if_ready) | (dm_req & ~dm_ready)
//   err        : sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DM_STREAK = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   // shared memory
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   // status
   output logic        stall,
   output logic        err
);

   localparam int SW = (DM_STREAK < 1) ? 1 : $clog2(DM_STREAK + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [SW-1:0] STREAK_MAX = SW'(DM_STREAK);
   // The counter holds the number of ack-less BUSY cycles already finished.
   // A timeout fires on the cycle that would push it to TIMEOUT.
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_gnt_if;      // 1 = in-flight access belongs to fetch
   logic [SW-1:0]   r_streak;      // data grants made while a fetch waited
   logic [TW-1:0]   r_tcnt;        // ack-less BUSY cycles so far

   logic            w_any_req;
   logic            w_grant_if;
   logic            w_timeout;
   logic            w_done;
   logic [31:0]     w_if_cap;
   logic [31:0]     w_dm_cap;
   logic            w_unused_addr_lsbs;

   // Next streak value after a grant. Only a data grant made while a fetch
   // is pending extends the streak. Any other grant restarts it.
   function automatic logic [SW-1:0] streak_next(
      input logic [SW-1:0] cur,
      input logic          grant_if,
      input logic          if_pending
   );
      if (grant_if || !if_pending) begin
         return '0;
      end else if (cur == STREAK_MAX) begin
         return cur;
      end else begin
         return cur + 1'b1;
      end
   endfunction

   // Memory is word addressed, so the byte-offset bits are dropped.
   assign w_unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

   assign w_any_req  = if_req | dm_req;
   // Fetch wins only when it is alone, or when data has used its streak.
   assign w_grant_if = if_req & (~dm_req | (r_streak == STREAK_MAX));

   // A real ack in the same cycle as the timeout counts as a normal ack.
   assign w_timeout  = ~mem_ack & (r_tcnt == TMO_LAST);
   assign w_done     = mem_ack | w_timeout;

   // Read data returned to the requester. A timeout returns zero, and so
   // does a store.
   assign w_if_cap   = mem_ack ? mem_rdata : '0;
   assign w_dm_cap   = (mem_ack & ~mem_we) ? mem_rdata : '0;

   // Reset gates stall so every output reads zero while rst is high.
   assign stall = ~rst & ((if_req & ~if_ready) | (dm_req & ~dm_ready));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt_if  <= 1'b0;
         r_streak  <= '0;
         r_tcnt    <= '0;
         if_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_rdata  <= '0;
         dm_ready  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  // The mem_* registers latch the granted request. Input
                  // changes after this edge cannot disturb the access.
                  r_state  <= ST_BUSY;
                  r_gnt_if <= w_grant_if;
                  r_tcnt   <= '0;
                  r_streak <= streak_next(r_streak, w_grant_if, if_req);
                  mem_req  <= 1'b1;
                  if (w_grant_if) begin
                     mem_we    <= 1'b0;
                     mem_addr  <= {if_addr[31:2], 2'b00};
                     mem_wdata <= '0;
                  end else begin
                     mem_we    <= dm_we;
                     mem_addr  <= {dm_addr[31:2], 2'b00};
                     mem_wdata <= dm_wdata;
                  end
               end
            end

            ST_BUSY: begin
               if (w_done) begin
                  r_state   <= ST_RESP;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  if (w_timeout) begin
                     err <= 1'b1;
                  end
                  if (r_gnt_if) begin
                     if_rdata <= w_if_cap;
                     if_ready <= 1'b1;
                  end else begin
                     dm_rdata <= w_dm_cap;
                     dm_ready <= 1'b1;
                  end
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end

            ST_RESP: begin
               // Requests are ignored here. A requester that just saw its
               // ready pulse has time to drop req before IDLE samples again.
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               r_state  <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int DM_STREAK = 4;
   localparam int TIMEOUT   = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        stall;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: plain integer streak and sticky error.
   int m_streak = 0;
   bit m_err    = 1'b0;

   mem_arbiter #(.DM_STREAK(DM_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ifr;
      logic [31:0] ia;
      bit          dmr;
      bit          dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [31:0] rd;
      int          lat;
      bit          gif;
      logic [31:0] ma;
      bit          mwe;
      logic [31:0] mwd;
      logic [31:0] erd;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   // Arbitration rule: data first, unless the fetch has waited through
   // DM_STREAK data grants.
   function automatic bit mdl_pick(input bit ifr, input bit dmr);
      return ifr && (!dmr || m_streak == DM_STREAK);
   endfunction

   task automatic mdl_grant(input bit gif, input bit ifr);
      if (gif || !ifr) m_streak = 0;
      else if (m_streak < DM_STREAK) m_streak = m_streak + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_streak = 0;
      m_err = 1'b0;
   endtask

   // Entered at a negedge while the DUT is in IDLE with requests driven.
   // The memory acks after lat wait cycles, or never when tmo=1.
   task automatic run_access(input bit gif, input logic [31:0] ea, input bit ewe,
                             input logic [31:0] ewd, input logic [31:0] erd,
                             input int lat, input logic [31:0] rd, input bit tmo,
                             input string tag);
      logic [31:0] s_ia, s_da, s_dwd;
      logic        s_dwe;
      bit          early;
      bit          done;
      int          nb;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".mem_req"},   mem_req, 1);
      chk({tag, ".mem_addr"},  mem_addr, ea);
      chk({tag, ".mem_we"},    mem_we, ewe);
      chk({tag, ".mem_wdata"}, mem_wdata, ewd);
      // Scramble the request-side inputs while the access is in flight.
      s_ia = if_addr; s_da = dm_addr; s_dwd = dm_wdata; s_dwe = dm_we;
      if_addr = $urandom(); dm_addr = $urandom(); dm_wdata = $urandom();
      dm_we = 1'($urandom_range(0, 1));
      early = 1'b0;
      done = 1'b0;
      nb = 1;
      while (!done) begin
         mem_ack = !tmo && (nb == lat + 1);
         mem_rdata = mem_ack ? rd : $urandom();
         @(posedge clk);
         @(negedge clk);
         if (mem_ack || (tmo && nb >= TIMEOUT)) begin
            done = 1'b1;
         end else begin
            if (if_ready || dm_ready || !mem_req) early = 1'b1;
            nb++;
            if (nb > TIMEOUT + 8) begin
               fail_now({tag, ".busy_bound"});
               done = 1'b1;
            end
         end
      end
      chk({tag, ".early_done"}, early, 0);
      if (tmo) m_err = 1'b1;
      // Acks outside BUSY must have no effect.
      mem_ack = 1'($urandom_range(0, 1));
      if_addr = s_ia; dm_addr = s_da; dm_wdata = s_dwd; dm_we = s_dwe;
      chk({tag, ".if_ready"}, if_ready, gif);
      chk({tag, ".dm_ready"}, dm_ready, !gif);
      if (gif) chk({tag, ".if_rdata"}, if_rdata, erd);
      else     chk({tag, ".dm_rdata"}, dm_rdata, erd);
      chk({tag, ".err"}, err, m_err);
      chk({tag, ".mem_req_resp"}, mem_req, 0);
      chk({tag, ".stall_resp"}, stall, (if_req & !gif) | (dm_req & gif));
      if (gif) if_req = 1'b0;
      else     dm_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".ready_off"}, {if_ready, dm_ready}, 0);
      chk({tag, ".mem_req_idle"}, mem_req, 0);
      chk({tag, ".stall_idle"}, stall, if_req | dm_req);
      mem_ack = 1'($urandom_range(0, 1));
   endtask

   // Expectations come from the model and the currently driven inputs.
   task automatic predicted_access(input int lat, input logic [31:0] rd, input bit tmo,
                                   input string tag);
      bit          gif;
      logic [31:0] ea, ewd, erd;
      bit          ewe;
      gif = mdl_pick(if_req, dm_req);
      ea  = (gif ? if_addr : dm_addr) & 32'hFFFF_FFFC;
      ewe = gif ? 1'b0 : dm_we;
      ewd = gif ? 32'h0 : dm_wdata;
      if (tmo)            erd = 32'h0;
      else if (gif)       erd = rd;
      else                erd = dm_we ? 32'h0 : rd;
      mdl_grant(gif, if_req);
      run_access(gif, ea, ewe, ewd, erd, lat, rd, tmo, tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit any_ready;

      vt[0] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2002_0005, 0,
                1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'h2002_0005};
      vt[1] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h13, 32'hAA55, 32'h1234_5678, 0,
                1'b0, 32'h0000_0010, 1'b1, 32'hAA55, 32'h0};
      vt[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h2003, 32'h5555, 32'hDEAD_BEEF, 1,
                1'b0, 32'h0000_2000, 1'b0, 32'h5555, 32'hDEAD_BEEF};
      vt[3] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 3,
                1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hCAFE_F00D};
      vt[4] = '{1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h8, 32'h77, 32'h1, 0,
                1'b0, 32'h0000_0008, 1'b0, 32'h77, 32'h1};
      vt[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'hABCD, 2,
                1'b0, 32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 32'h0};

      // Reset state, with requests already high.
      if_req = 1'b1;
      dm_req = 1'b1;
      #1;
      chk("rst.mem_req", mem_req, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.ready", {if_ready, dm_ready}, 0);
      chk("rst.if_rdata", if_rdata, 0);
      chk("rst.dm_rdata", dm_rdata, 0);
      chk("rst.err", err, 0);
      chk("rst.stall", stall, 0);

      // Table-driven single accesses, each from a fresh reset.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         if_req = vt[i].ifr; if_addr = vt[i].ia;
         dm_req = vt[i].dmr; dm_we = vt[i].dwe; dm_addr = vt[i].da; dm_wdata = vt[i].dwd;
         run_access(vt[i].gif, vt[i].ma, vt[i].mwe, vt[i].mwd, vt[i].erd,
                    vt[i].lat, vt[i].rd, 1'b0, $sformatf("vec%0d", i));
      end

      // Data is granted first, then the held fetch.
      do_reset();
      if_req = 1'b1; if_addr = 32'h104;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h13; dm_wdata = 32'hAA55;
      run_access(1'b0, 32'h10, 1'b1, 32'hAA55, 32'h0, 0, 32'h9, 1'b0, "both.d");
      run_access(1'b1, 32'h104, 1'b0, 32'h0, 32'h3333, 0, 32'h3333, 1'b0, "both.i");

      // Streak limit: D,D,D,D,I repeating while both keep requesting.
      do_reset();
      if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0; dm_wdata = 32'h0;
      for (int g = 0; g < 10; g++) begin
         if_req = 1'b1;
         dm_req = 1'b1;
         if (g % 5 == 4)
            run_access(1'b1, 32'h100, 1'b0, 32'h0, 32'h1000 + g, 0, 32'h1000 + g, 1'b0,
                       $sformatf("streak%0d", g));
         else
            run_access(1'b0, 32'h200, 1'b0, 32'h0, 32'h2000 + g, 0, 32'h2000 + g, 1'b0,
                       $sformatf("streak%0d", g));
      end

      // Timeout with no ack, err sticky through a later normal access.
      do_reset();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
      predicted_access(0, 32'h0, 1'b1, "tmo");
      if_req = 1'b1; if_addr = 32'h44;
      predicted_access(1, 32'h4444, 1'b0, "tmo.after");
      do_reset();
      chk("tmo.err_cleared", err, 0);

      // Ack in the very cycle the timeout would fire.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      predicted_access(TIMEOUT - 1, 32'h600D_0047, 1'b0, "ack_at_tmo");
      chk("ack_at_tmo.err", err, 0);

      // Reset in the middle of BUSY.
      do_reset();
      if_req = 1'b1; if_addr = 32'h60;
      predicted_access(0, 32'h5A5A_0001, 1'b0, "pre_rst");
      if_req = 1'b1; if_addr = 32'h200;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst.mem_req", mem_req, 0);
      chk("midrst.mem_addr", mem_addr, 0);
      chk("midrst.if_rdata", if_rdata, 0);
      chk("midrst.stall", stall, 0);
      if_req = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      rst = 1'b0;
      m_streak = 0;
      m_err = 1'b0;
      any_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         mem_ack = 1'b0;
         if (if_ready || dm_ready || mem_req) any_ready = 1'b1;
      end
      chk("midrst.no_pulse", any_ready, 0);
      if_req = 1'b1; if_addr = 32'h300;
      predicted_access(0, 32'h0000_0077, 1'b0, "post_rst");

      // Randomized traffic against the model.
      do_reset();
      for (int it = 0; it < 300; it++) begin
         if (!if_req && $urandom_range(0, 3) != 0) begin
            if_req = 1'b1;
            if_addr = $urandom();
         end
         if (!dm_req && $urandom_range(0, 3) != 0) begin
            dm_req = 1'b1;
            dm_we = 1'($urandom_range(0, 1));
            dm_addr = $urandom();
            dm_wdata = $urandom();
         end
         if (!if_req && !dm_req) begin
            @(posedge clk);
            @(negedge clk);
            chk("rnd.idle_mem_req", mem_req, 0);
            chk("rnd.idle_ready", {if_ready, dm_ready}, 0);
            mem_ack = 1'($urandom_range(0, 1));
         end else begin
            predicted_access($urandom_range(0, 3), $urandom(), 1'b0, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
